// File: rtl/mdu_pkg.sv
// ============================================================================
// Module      : mdu_pkg
// Description : Shared op encoding and latency constants for the multiply /
//               divide unit and the controller that issues to it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } mdu_op_e;

  // Number of busy cycles after acceptance.
  localparam logic [3:0] MULT_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT  = 4'd10;

endpackage

`default_nettype wire

// File: rtl/mdu_arith.sv
// ============================================================================
// Module      : mdu_arith
// Description : Combinational product / quotient / remainder for the latched
//               operands. Signed division works on magnitudes so the
//               0x80000000 / -1 case wraps cleanly to 0x80000000 rem 0.
//               A zero divisor deasserts we_o so HI/LO keep their contents.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_b_zero;
  logic [31:0] w_b_safe;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_quo_u;
  logic [31:0] w_rem_u;
  logic [31:0] w_quo_m;
  logic [31:0] w_rem_m;
  logic [31:0] w_quo_s;
  logic [31:0] w_rem_s;

  // Sign-extended operands multiplied modulo 2^64 give the signed product.
  assign w_prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
  assign w_prod_u = {32'd0, a_i} * {32'd0, b_i};

  // Substitute divisor 1 for 0 so the dividers never see a zero; the result
  // is discarded via we_o in that case.
  assign w_b_zero = (b_i == 32'd0);
  assign w_b_safe = w_b_zero ? 32'd1 : b_i;
  assign w_abs_a  = a_i[31] ? (~a_i + 32'd1) : a_i;
  assign w_abs_b  = w_b_zero ? 32'd1 : (b_i[31] ? (~b_i + 32'd1) : b_i);

  assign w_quo_u = a_i / w_b_safe;
  assign w_rem_u = a_i % w_b_safe;
  assign w_quo_m = w_abs_a / w_abs_b;
  assign w_rem_m = w_abs_a % w_abs_b;

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign w_quo_s = (a_i[31] ^ b_i[31]) ? (~w_quo_m + 32'd1) : w_quo_m;
  assign w_rem_s = a_i[31] ? (~w_rem_m + 32'd1) : w_rem_m;

  // Select the result pair for the latched operation.
  always_comb begin
    we_o = 1'b0;
    hi_o = 32'd0;
    lo_o = 32'd0;
    case (op_i)
      OP_MULT: begin
        we_o         = 1'b1;
        {hi_o, lo_o} = w_prod_s;
      end
      OP_MULTU: begin
        we_o         = 1'b1;
        {hi_o, lo_o} = w_prod_u;
      end
      OP_DIV: begin
        we_o = ~w_b_zero;
        hi_o = w_rem_s;
        lo_o = w_quo_s;
      end
      OP_DIVU: begin
        we_o = ~w_b_zero;
        hi_o = w_rem_u;
        lo_o = w_quo_u;
      end
      default: begin
        we_o = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module      : mult_div_unit
// Description : Multi-cycle multiply/divide unit with architectural HI/LO.
//               Operands are latched at acceptance; HI/LO change only when
//               the busy period ends, so intermediate results never show.
//               Build option MDU_UNSIGNED_OPS_EN enables MULTU/DIVU; without
//               it those encodings are treated as no-ops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  op_q, op_d;

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_res_we;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

`ifdef MDU_UNSIGNED_OPS_EN
  assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign w_is_div = (op == OP_DIV)  || (op == OP_DIVU);
`else
  assign w_is_mul = (op == OP_MULT);
  assign w_is_div = (op == OP_DIV);
`endif

  mdu_arith u_arith (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .we_o (w_res_we),
    .hi_o (w_res_hi),
    .lo_o (w_res_lo)
  );

  // Next state: count down while busy, otherwise accept arithmetic or moves.
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    a_d    = a_q;
    b_d    = b_q;
    op_d   = op_q;
    if (busy_q) begin
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        cnt_d  = 4'd0;
        if (w_res_we) begin
          hi_d = w_res_hi;
          lo_d = w_res_lo;
        end
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (start) begin
      if (w_is_mul || w_is_div) begin
        busy_d = 1'b1;
        cnt_d  = w_is_div ? DIV_LAT : MULT_LAT;
        a_d    = srcA;
        b_d    = srcB;
        op_d   = op;
      end else if (op == OP_MTHI) begin
        hi_d = srcA;
      end else if (op == OP_MTLO) begin
        lo_d = srcA;
      end
    end
  end

  // State registers; reset clears everything and aborts any running op.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= 4'd0;
      busy_q <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      op_q   <= 4'd0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      a_q    <= a_d;
      b_q    <= b_d;
      op_q   <= op_d;
    end
  end

  assign busy  = busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign rdata = (op == OP_MFHI) ? hi_q : lo_q;

endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request qualifier for op.
REQ-004 SHALL have port op, input, 4 bits: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
REQ-005 SHALL have ports srcA and srcB, input, 32 bits each: GRF rs/rt operand values.
REQ-006 SHALL have port busy, output, 1 bit: arithmetic in progress.
REQ-007 SHALL have ports hi and lo, output, 32 bits each: architectural HI/LO registers.
REQ-008 SHALL have port rdata, output, 32 bits: combinational read data, hi when op==MFHI, otherwise lo.

Function
REQ-009 SHALL accept an arithmetic op only when start=1, busy=0 and op is MULT/MULTU/DIV/DIVU; SHALL latch srcA, srcB and op on that edge.
REQ-010 SHALL assert busy from the cycle after acceptance: 5 cycles for MULT/MULTU, 10 cycles for DIV/DIVU.
REQ-011 SHALL update hi/lo on the edge that ends the last busy cycle; busy SHALL be 0 in the following cycle.
REQ-012 SHALL ignore start with any op while busy=1; the running operation and hi/lo SHALL be unaffected.
REQ-013 SHALL accept a new arithmetic op in the same cycle that busy falls (back-to-back issue, no gap).
REQ-014 MULT/MULTU: {hi,lo} = 64-bit signed/unsigned product of srcA*srcB.
REQ-015 DIV/DIVU: lo = quotient, hi = remainder. Signed quotient SHALL truncate toward zero; remainder SHALL take the sign of the dividend.
REQ-016 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000.
REQ-017 Divisor 0 SHALL still run the full 10-cycle busy period; hi/lo SHALL remain unchanged.
REQ-018 MTHI/MTLO with start=1 and busy=0 SHALL write srcA into hi/lo on the next edge, with no busy assertion.
REQ-019 MFHI/MFLO SHALL NOT change state; rdata is valid only while busy=0.
REQ-020 hi/lo SHALL show old values throughout busy; intermediate results SHALL NOT be visible.
REQ-021 op=NONE or an unused encoding with start=1 SHALL be a no-op.

Reset
REQ-022 reset=1 at an edge SHALL clear hi, lo, busy, the cycle counter and the latched operands to 0, overriding start.
REQ-023 reset during busy SHALL abort the operation; hi/lo SHALL be 0 next cycle, and no late write-back SHALL occur.

Configuration
REQ-024 Macro MDU_UNSIGNED_OPS_EN defined: MULTU/DIVU SHALL behave per REQ-014/015.
REQ-025 Macro MDU_UNSIGNED_OPS_EN undefined: MULTU/DIVU SHALL be treated as NONE (no busy, no hi/lo change).

Structure
REQ-026 SHALL place the op encoding and the constants MULT_LAT=5 and DIV_LAT=10 in shared package mdu_pkg, for use by this block and by Controller.
REQ-027 SHALL put the combinational product/quotient/remainder logic, including the signed/unsigned and divide-by-zero handling, in sub-module mdu_arith. The counter, busy and hi/lo registers SHALL stay in mult_div_unit.

Verification
REQ-028 MULT srcA=0xFFFFFFFE, srcB=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-029 DIV srcA=0xFFFFFFF9 (-7), srcB=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU on the same operands -> lo=0x7FFFFFFC, hi=1.
REQ-030 MTHI 0x1234 issued during DIV busy, then MFHI after busy clears -> hi equals the DIV remainder, not 0x1234.
REQ-031 DIV srcB=0 with hi=0xAA, lo=0xBB preloaded -> busy 10 cycles; hi/lo remain 0xAA/0xBB.
REQ-032 reset asserted at busy cycle 3 of MULT -> busy=0, hi=lo=0 next cycle, no later update.
REQ-033 MDU_UNSIGNED_OPS_EN undefined, MULTU 2*3 -> busy stays 0 and hi/lo are unchanged.
